// File: rtl/fft_pkg.sv
// Shared FFT unload types and helpers.
// Bit reversal and parity map k onto the banked in-place storage.
package fft_pkg;

    localparam int FFT_LOG2N = 6;
    localparam int FFT_N     = 64;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_READ,
        RD_DRAIN
    } rd_state_t;

    function automatic logic [5:0] bitrev6(input logic [5:0] v);
        return {v[0], v[1], v[2], v[3], v[4], v[5]};
    endfunction

    function automatic logic parity6(input logic [5:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/fft_out_fifo.sv
// Two-entry output FIFO carrying {last, index, data}.
// Absorbs the one-cycle read latency so backpressure loses nothing.
module fft_out_fifo #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              push,
    input  logic              push_last,
    input  logic [IDX_W-1:0]  push_idx,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        count,
    output logic              valid,
    output logic              head_last,
    output logic [IDX_W-1:0]  head_idx,
    output logic [DATA_W-1:0] head_data
);

    localparam int W = DATA_W + IDX_W + 1;

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign valid   = (count != 2'd0);
    assign {head_last, head_idx, head_data} = mem[rd_ptr];

    // Storage, pointers and occupancy; pointers wrap naturally at 2 entries.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= {push_last, push_idx, push_data};
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fft_result_reader.sv
// Unloads bit-reversed, parity-banked FFT results in natural order.
// One read in flight feeds a 2-deep FIFO for full-rate streaming.
module fft_result_reader
    import fft_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LOG2N  = 6
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    output logic              re_b0,
    output logic              re_b1,
    output logic [LOG2N-2:0]  raddr_b0,
    output logic [LOG2N-2:0]  raddr_b1,
    input  logic [DATA_W-1:0] rdata_b0,
    input  logic [DATA_W-1:0] rdata_b1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [LOG2N-1:0]  out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    rd_state_t        state;
    logic [LOG2N:0]   rk;
    logic [LOG2N-1:0] rk_k;
    logic [LOG2N-1:0] rd_n;
    logic             rd_bank;
    logic [LOG2N-2:0] rd_addr;
    logic             issue;
    logic             pop;
    logic [1:0]       fifo_count;
    logic [2:0]       occ;
    logic             drain_done;

    logic             infl_v;
    logic             infl_bank;
    logic [LOG2N-1:0] infl_idx;
    logic [DATA_W-1:0] ret_data;

    assign rk_k    = rk[LOG2N-1:0];
    assign rd_bank = parity6(rk_k);
    assign rd_n    = bitrev6(rk_k);
    assign rd_addr = rd_n[LOG2N-1:1];

    assign pop   = out_valid && out_ready;
    assign occ   = {1'b0, fifo_count} + {2'b00, infl_v};
    assign issue = (state == RD_READ) && !rk[LOG2N]
                 && (occ < (3'd2 + {2'b00, pop}));

    assign re_b0    = issue && !rd_bank;
    assign re_b1    = issue && rd_bank;
    assign raddr_b0 = re_b0 ? rd_addr : '0;
    assign raddr_b1 = re_b1 ? rd_addr : '0;

    assign drain_done = !infl_v && (fifo_count == {1'b0, pop});
    assign ret_data   = infl_bank ? rdata_b1 : rdata_b0;

    // Unload FSM: read counter plus registered busy/done.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= RD_IDLE;
            rk    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                RD_IDLE: begin
                    if (start) begin
                        state <= RD_READ;
                        rk    <= '0;
                        busy  <= 1'b1;
                    end
                end
                RD_READ: begin
                    if (issue) begin
                        rk <= rk + 1'b1;
                    end
                    if (rk[LOG2N]) begin
                        state <= RD_DRAIN;
                    end
                end
                RD_DRAIN: begin
                    if (drain_done) begin
                        state <= RD_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

    // Tag of the read in flight; data returns on the next cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            infl_v    <= 1'b0;
            infl_bank <= 1'b0;
            infl_idx  <= '0;
        end else begin
            infl_v    <= issue;
            infl_bank <= rd_bank;
            infl_idx  <= rk_k;
        end
    end

    fft_out_fifo #(
        .DATA_W (DATA_W),
        .IDX_W  (LOG2N)
    ) u_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .push      (infl_v),
        .push_last (&infl_idx),
        .push_idx  (infl_idx),
        .push_data (ret_data),
        .pop       (pop),
        .count     (fifo_count),
        .valid     (out_valid),
        .head_last (out_last),
        .head_idx  (out_index),
        .head_data (out_data)
    );

endmodule

// File: tb/tb_fft_result_reader.sv
// Directed bench for fft_result_reader.
// Banks preloaded so location n holds n; X[k] must equal bitrev(k).
module tb_fft_result_reader;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic        re_b0, re_b1;
    logic [4:0]  raddr_b0, raddr_b1;
    logic [31:0] rdata_b0, rdata_b1;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] bank0 [32];
    logic [31:0] bank1 [32];

    int n_checks = 0;
    int n_errors = 0;

    fft_result_reader dut (
        .clk       (clk),
        .nrst      (nrst),
        .start     (start),
        .re_b0     (re_b0),
        .re_b1     (re_b1),
        .raddr_b0  (raddr_b0),
        .raddr_b1  (raddr_b1),
        .rdata_b0  (rdata_b0),
        .rdata_b1  (rdata_b1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM model: one-cycle read latency.
    always @(posedge clk) begin
        if (re_b0) rdata_b0 <= bank0[raddr_b0];
        if (re_b1) rdata_b1 <= bank1[raddr_b1];
    end

    function automatic int brev(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 6; i++) begin
            if (((v >> i) & 1) != 0) r = r | (1 << (5 - i));
        end
        return r;
    endfunction

    function automatic int par(input int v);
        int p;
        p = 0;
        for (int i = 0; i < 6; i++) p = p ^ ((v >> i) & 1);
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Caller is at a negedge; returns at the negedge after start is sampled.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: ready high, 1: ready 1,0,0,1, 2: ready low for 20 cycles.
    task automatic stream(input int mode, input int restart_k, input bit bb,
                          input int exp_done, input string tag);
        int k_exp, cyc, first_v, done_cyc, reads, both;
        bit r, held, restarted, busy_at_done;
        logic [31:0] h_data;
        logic [5:0]  h_idx;
        k_exp = 0; cyc = 0; first_v = -1; done_cyc = -1;
        reads = 0; both = 0; held = 0; restarted = 0; busy_at_done = 1;
        h_data = '0; h_idx = '0;
        while (cyc < 400 && done_cyc < 0) begin
            start = 1'b0;
            if (re_b0 && re_b1) both++;
            reads += int'(re_b0) + int'(re_b1);
            case (mode)
                1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
                2:       r = (cyc >= 20);
                default: r = 1'b1;
            endcase
            out_ready = r;
            if (mode == 2 && cyc == 19) begin
                check({tag, "_stall_reads"}, reads, 2);
                check({tag, "_stall_valid"}, {out_valid, 2'b0, out_index}, 9'h100);
            end
            if (done) begin
                done_cyc = cyc;
                busy_at_done = busy;
                if (bb) start = 1'b1;
            end
            if (out_valid && k_exp < 64) begin
                if (first_v < 0) first_v = cyc;
                if (held) begin
                    check({tag, "_hold_data"}, out_data, h_data);
                    check({tag, "_hold_idx"}, out_index, h_idx);
                end
                check({tag, "_idx"}, out_index, k_exp);
                check({tag, "_data"}, out_data, brev(k_exp));
                check({tag, "_last"}, out_last, k_exp == 63);
                if (r) begin
                    k_exp++;
                    held = 0;
                end else begin
                    held = 1;
                    h_data = out_data;
                    h_idx = out_index;
                end
            end
            if (restart_k >= 0 && !restarted && k_exp == restart_k) begin
                start = 1'b1;
                restarted = 1;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, done_cyc >= 0, 1);
        check({tag, "_beats"}, k_exp, 64);
        check({tag, "_first_valid"}, first_v, 2);
        check({tag, "_busy_at_done"}, busy_at_done, 0);
        check({tag, "_one_bank"}, both, 0);
        check({tag, "_done_pulse"}, done, 0);
        if (exp_done >= 0) check({tag, "_done_cyc"}, done_cyc, exp_done);
    endtask

    initial begin
        int bad, guard;
        for (int n = 0; n < 64; n++) begin
            if (par(n) != 0) bank1[n >> 1] = n;
            else bank0[n >> 1] = n;
        end
        rdata_b0 = '0;
        rdata_b1 = '0;
        nrst = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outs", {out_valid, busy, done, re_b0, re_b1, out_last}, 6'd0);
        check("rst_data", out_data, 0);
        nrst = 1'b1;
        @(negedge clk);

        pulse_start();
        check("t1_busy_rise", busy, 1);
        stream(0, -1, 1'b0, 66, "t1");
        @(negedge clk);

        pulse_start();
        stream(1, -1, 1'b0, -1, "t2");
        @(negedge clk);

        pulse_start();
        stream(2, -1, 1'b0, -1, "t3");
        @(negedge clk);

        pulse_start();
        stream(0, 10, 1'b0, 66, "t4");
        @(negedge clk);

        pulse_start();
        out_ready = 1'b1;
        guard = 0;
        while (!(out_valid && out_index == 6'd30) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("t5_reach_k30", guard < 200, 1);
        nrst = 1'b0;
        #1;
        check("t5_rst_outs", {out_valid, busy, done, re_b0, re_b1, out_last}, 6'd0);
        check("t5_rst_data", {out_data[25:0], out_index}, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy || out_valid) bad++;
        end
        check("t5_no_done", bad, 0);
        pulse_start();
        stream(0, -1, 1'b0, 66, "t5");
        @(negedge clk);

        pulse_start();
        stream(0, -1, 1'b1, 66, "t6a");
        stream(0, -1, 1'b0, 66, "t6b");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
